// File: rtl/seg7_scan_controller.sv
// Multiplexed seven-segment display controller.
// Scans NUM_DIGITS common-anode digits, one slot of REFRESH_DIV clocks per digit.
// A ready/valid load port feeds a pending register. Pending data is committed to
// the display register only at a frame boundary, so a frame never shows a mix of
// old and new values. Optional leading-zero blanking is applied per loaded value.
module seg7_scan_controller #(
    parameter int REFRESH_DIV = 10000,
    parameter int NUM_DIGITS  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   load_dp,
    input  logic                    load_blz,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [PW-1:0]           pre_cnt;
    logic [IW-1:0]           idx;
    logic                    tick;
    logic                    boundary;
    logic                    accept;
    logic                    commit;

    logic [4*NUM_DIGITS-1:0] pend_data;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic                    pend_blz;
    logic [4*NUM_DIGITS-1:0] disp_data;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic                    disp_blz;

    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    blank;
    logic [NUM_DIGITS-1:0]   an_nxt;
    logic [NUM_DIGITS-1:0]   upper_zero;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign tick     = (pre_cnt == PRE_MAX);
    assign boundary = tick && (idx == IDX_MAX);
    assign accept   = load_valid && load_ready;
    assign commit   = (state == HOLD) && boundary;

    // Prescaler: divides clk down to the per-digit slot rate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       pre_cnt <= '0;
        else if (tick) pre_cnt <= '0;
        else           pre_cnt <= pre_cnt + 1'b1;
    end

    // Digit index advances once per slot and wraps at the last digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       idx <= '0;
        else if (tick) idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
    end

    // One-cycle frame pulse, registered one cycle after the boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) frame_done <= 1'b0;
        else     frame_done <= boundary;
    end

    // Load FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    // Load FSM next state: EMPTY fills on handshake, HOLD drains at a boundary.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (accept) state_nxt = HOLD;
            HOLD:    if (boundary) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // Load FSM outputs.
    always_comb begin
        load_ready = (state == EMPTY);
    end

    // Pending register captures the offered value on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_data <= '0;
            pend_dp   <= '0;
            pend_blz  <= 1'b0;
        end else if (accept) begin
            pend_data <= load_data;
            pend_dp   <= load_dp;
            pend_blz  <= load_blz;
        end
    end

    // Display register only changes at a frame boundary, never mid-frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_data <= '0;
            disp_dp   <= '0;
            disp_blz  <= 1'b0;
        end else if (commit) begin
            disp_data <= pend_data;
            disp_dp   <= pend_dp;
            disp_blz  <= pend_blz;
        end
    end

    // Select the active digit, build the anode pattern and the blanking decision.
    always_comb begin
        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        blank      = 1'b0;
        an_nxt     = '1;
        upper_zero = '0;
        // upper_zero[k]: nibble k and every nibble above it are zero.
        upper_zero[NUM_DIGITS-1] = (disp_data[4*NUM_DIGITS-1 -: 4] == 4'h0);
        for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
            upper_zero[k] = upper_zero[k+1] && (disp_data[4*k +: 4] == 4'h0);
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                cur_nib   = disp_data[4*k +: 4];
                cur_dp    = disp_dp[k];
                an_nxt[k] = 1'b0;
                blank     = disp_blz && (k != 0) && upper_zero[k];
            end
        end
    end

    // Registered display drive so an, seg and dp switch together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= '1;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= an_nxt;
            seg <= blank ? 7'h7F : hex_to_seg(cur_nib);
            dp  <= blank ? 1'b1 : ~cur_dp;
        end
    end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Randomized self-checking bench for seg7_scan_controller (REFRESH_DIV=4, NUM_DIGITS=8).
// The reference model derives the active digit and frame boundaries from a cycle
// count since reset release and models the load path as a one-entry buffer.
module tb_seg7_scan_controller;

    localparam int RD    = 4;
    localparam int ND    = 8;
    localparam int FRAME = RD * ND;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [31:0] load_data = '0;
    logic [7:0]  load_dp = '0;
    logic        load_blz = 1'b0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seg7_scan_controller #(
        .REFRESH_DIV(RD),
        .NUM_DIGITS (ND)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_data (load_data),
        .load_dp   (load_dp),
        .load_blz  (load_blz),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .frame_done(frame_done)
    );

    logic [6:0] seg_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model state
    int          m_t;
    logic [31:0] m_data;
    logic [7:0]  m_dpv;
    logic        m_blz;
    logic        m_pv;
    logic [31:0] p_data;
    logic [7:0]  p_dpv;
    logic        p_blz;
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_fd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0d)", tag, got, exp, m_t);
        end
    endtask

    function automatic bit blanked(input int k);
        return m_blz && (k >= 1) && ((m_data >> (4 * k)) == 32'd0);
    endfunction

    task automatic model_reset();
        m_t    = 0;
        m_data = '0;
        m_dpv  = '0;
        m_blz  = 1'b0;
        m_pv   = 1'b0;
        p_data = '0;
        p_dpv  = '0;
        p_blz  = 1'b0;
        e_an   = 8'hFF;
        e_seg  = 7'h7F;
        e_dp   = 1'b1;
        e_fd   = 1'b0;
    endtask

    // One rising edge of the reference model, using inputs present at that edge.
    task automatic model_step();
        int k;
        bit bnd;
        k   = (m_t / RD) % ND;
        bnd = (m_t % FRAME) == FRAME - 1;
        e_an = ~(8'd1 << k);
        if (blanked(k)) begin
            e_seg = 7'h7F;
            e_dp  = 1'b1;
        end else begin
            e_seg = seg_lut[(m_data >> (4 * k)) & 32'hF];
            e_dp  = ~m_dpv[k];
        end
        e_fd = bnd;
        if (m_pv) begin
            if (bnd) begin
                m_data = p_data;
                m_dpv  = p_dpv;
                m_blz  = p_blz;
                m_pv   = 1'b0;
            end
        end else if (load_valid) begin
            p_data = load_data;
            p_dpv  = load_dp;
            p_blz  = load_blz;
            m_pv   = 1'b1;
        end
        m_t++;
    endtask

    task automatic check_outputs();
        check("an", 32'(an), 32'(e_an));
        check("seg", 32'(seg), 32'(e_seg));
        check("dp", 32'(dp), 32'(e_dp));
        check("frame_done", 32'(frame_done), 32'(e_fd));
        check("load_ready", 32'(load_ready), 32'(!m_pv));
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_an"}, 32'(an), 32'hFF);
        check({pfx, "_seg"}, 32'(seg), 32'h7F);
        check({pfx, "_dp"}, 32'(dp), 32'h1);
        check({pfx, "_frame_done"}, 32'(frame_done), 32'h0);
        check({pfx, "_load_ready"}, 32'(load_ready), 32'h1);
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic [7:0] p, input logic b);
        @(negedge clk);
        check_outputs();
        load_valid = v;
        load_data  = d;
        load_dp    = p;
        load_blz   = b;
        @(posedge clk);
        if (!rst) model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, $urandom, 8'($urandom), 1'($urandom));
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 200; i++) begin
            if (!m_pv) return;
            idle(1);
        end
        check("wait_empty_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_empty_boundary();
        for (int i = 0; i < 200; i++) begin
            if (!m_pv && (m_t % FRAME) == FRAME - 1) return;
            idle(1);
        end
        check("wait_boundary_timeout", 32'd0, 32'd1);
    endtask

    task automatic reset_release();
        @(negedge clk);
        check_outputs();
        rst = 1'b0;
        @(posedge clk);
        model_step();
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b1;
        #3 check_reset_values("reset");
        idle(2);
        reset_release();

        // Free-running scan with no loads
        idle(70);

        // Mid-frame load
        idle(5);
        step(1'b1, 32'h1234_5678, 8'h00, 1'b0);
        idle(80);

        // Second value held valid while the first is pending
        wait_empty();
        step(1'b1, 32'h9ABC_DEF0, 8'h0F, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, 32'hCAFE_0001, 8'hF0, 1'b0);
        idle(70);

        // Leading-zero blanking
        wait_empty();
        step(1'b1, 32'h0000_00A0, 8'h01, 1'b1);
        idle(70);

        // Handshake coinciding with a frame boundary
        wait_empty_boundary();
        step(1'b1, 32'h0F0F_0F0F, 8'hAA, 1'b0);
        idle(70);

        // Randomized loads, with zero-heavy data to exercise blanking
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] d;
            d = $urandom >> $urandom_range(0, 32);
            step(($urandom % 6) == 0, d, 8'($urandom), 1'($urandom));
        end

        // Asynchronous reset while a value is pending
        wait_empty();
        step(1'b1, 32'h5555_5555, 8'hFF, 1'b0);
        idle(3);
        #2 rst = 1'b1;
        #1 check_reset_values("async_reset");
        model_reset();
        idle(2);
        reset_release();
        idle(70);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
